// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the parametrised FIFO
package fifo_pkg;
   localparam int FIFO_DATA_W_DEF = 16;
   localparam int FIFO_DEPTH_DEF  = 8;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction
endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DATA_W x DEPTH storage, synchronous write, asynchronous read
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W_DEF,
   parameter int DEPTH  = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [clog2(DEPTH)-1:0]  waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [clog2(DEPTH)-1:0]  raddr,
   output logic [DATA_W-1:0]        rdata
);

   // Contents are deliberately left unreset so this maps onto plain RAM.
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with count, thresholds, error pulses and FWFT option
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W    = FIFO_DATA_W_DEF,
   parameter int DEPTH     = FIFO_DEPTH_DEF,
   parameter int FWFT      = FIFO_STD,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    rd_en,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    full,
   output logic                    almost_full,
   output logic                    empty,
   output logic                    almost_empty,
   output logic [clog2(DEPTH):0]   count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int ADDR_W = clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AF_L    = PTR_W'(AF_THRESH);
   localparam logic [PTR_W-1:0] AE_L    = PTR_W'(AE_THRESH);

   if (DATA_W < 1) begin : g_bad_width
      $error("sync_fifo_param: DATA_W must be >= 1");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two >= 2");
   end
   if (AF_THRESH <= 0 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_param: AF_THRESH out of range");
   end
   if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
      $error("sync_fifo_param: AE_THRESH out of range");
   end

   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [PTR_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              almost_full_q, almost_full_d;
   logic              empty_q, empty_d;
   logic              almost_empty_q, almost_empty_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] mem_rdata;

   // Accepts use the registered flags, so a full FIFO still pops on a
   // simultaneous read while the write is dropped, and vice versa when empty.
   always_comb begin
      wr_acc = wr_en & ~full_q;
      rd_acc = rd_en & ~empty_q;

      wptr_d  = wr_acc ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d  = rd_acc ? rptr_q + PTR_W'(1) : rptr_q;

      count_d = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + PTR_W'(1);
         2'b01:   count_d = count_q - PTR_W'(1);
         default: count_d = count_q;
      endcase

      full_d         = (count_d == DEPTH_L);
      almost_full_d  = (count_d >= AF_L);
      empty_d        = (count_d == '0);
      almost_empty_d = (count_d <= AE_L);
      overflow_d     = wr_en & full_q;
      underflow_d    = rd_en & empty_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q         <= '0;
         rptr_q         <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         almost_full_q  <= 1'b0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         wptr_q         <= wptr_d;
         rptr_q         <= rptr_d;
         count_q        <= count_d;
         full_q         <= full_d;
         almost_full_q  <= almost_full_d;
         empty_q        <= empty_d;
         almost_empty_q <= almost_empty_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wptr_q[ADDR_W-1:0]),
      .wdata (wr_data),
      .raddr (rptr_q[ADDR_W-1:0]),
      .rdata (mem_rdata)
   );

   if (FWFT == FIFO_FWFT) begin : g_fwft
      assign rd_data = mem_rdata;
   end else begin : g_std
      logic [DATA_W-1:0] rd_data_q, rd_data_d;

      always_comb begin
         rd_data_d = rd_acc ? mem_rdata : rd_data_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_data_q <= '0;
         end else begin
            rd_data_q <= rd_data_d;
         end
      end

      assign rd_data = rd_data_q;
   end

   assign full         = full_q;
   assign almost_full  = almost_full_q;
   assign empty        = empty_q;
   assign almost_empty = almost_empty_q;
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed checks of sync_fifo_param in standard and FWFT modes
module tb_sync_fifo_param;

   logic        clk;
   logic        rst_n;

   logic        s_wr_en, s_rd_en;
   logic [15:0] s_wr_data, s_rd_data;
   logic        s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
   logic [3:0]  s_count;

   logic        f_wr_en, f_rd_en;
   logic [15:0] f_wr_data, f_rd_data;
   logic        f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
   logic [3:0]  f_count;

   int checks   = 0;
   int failures = 0;

   logic [15:0] q[$];

   sync_fifo_param #(.DATA_W(16), .DEPTH(8), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n),
      .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en), .rd_data(s_rd_data),
      .full(s_full), .almost_full(s_afull), .empty(s_empty), .almost_empty(s_aempty),
      .count(s_count), .overflow(s_ovf), .underflow(s_unf)
   );

   sync_fifo_param #(.DATA_W(16), .DEPTH(8), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n),
      .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en), .rd_data(f_rd_data),
      .full(f_full), .almost_full(f_afull), .empty(f_empty), .almost_empty(f_aempty),
      .count(f_count), .overflow(f_ovf), .underflow(f_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_std_reset(input string tag);
      check({tag, "_empty"},  32'(s_empty),   32'd1);
      check({tag, "_aempty"}, 32'(s_aempty),  32'd1);
      check({tag, "_full"},   32'(s_full),    32'd0);
      check({tag, "_afull"},  32'(s_afull),   32'd0);
      check({tag, "_count"},  32'(s_count),   32'd0);
      check({tag, "_ovf"},    32'(s_ovf),     32'd0);
      check({tag, "_unf"},    32'(s_unf),     32'd0);
      check({tag, "_rdata"},  32'(s_rd_data), 32'd0);
   endtask

   initial begin
      logic wr, rd, wacc, racc, exp_ovf;

      rst_n = 1'b0;
      s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;
      f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
      tick();
      tick();
      check_std_reset("rst_hold");
      rst_n = 1'b1;
      tick();
      check_std_reset("rst_idle");

      // Mid-stream asynchronous reset after five writes
      s_wr_en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         s_wr_data = 16'h0100 + 16'(i);
         tick();
      end
      s_wr_en = 1'b0;
      check("pre_rst_count", 32'(s_count), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check_std_reset("rst_async");
      tick();
      rst_n = 1'b1;
      tick();
      check_std_reset("rst_release");

      // Fill with 1..8
      s_wr_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         s_wr_data = 16'(i);
         tick();
         check("fill_count", 32'(s_count), 32'(i));
         check("fill_empty", 32'(s_empty), 32'd0);
         check("fill_afull", 32'(s_afull), (i >= 6) ? 32'd1 : 32'd0);
         check("fill_aempty", 32'(s_aempty), (i <= 2) ? 32'd1 : 32'd0);
         check("fill_full", 32'(s_full), (i == 8) ? 32'd1 : 32'd0);
      end

      // Overflow attempt with 0xDEAD
      s_wr_data = 16'hDEAD;
      tick();
      s_wr_en = 1'b0;
      check("ovf_pulse", 32'(s_ovf), 32'd1);
      check("ovf_count", 32'(s_count), 32'd8);
      check("ovf_full", 32'(s_full), 32'd1);
      tick();
      check("ovf_clear", 32'(s_ovf), 32'd0);
      check("ovf_count2", 32'(s_count), 32'd8);

      // Drain 1..8
      s_rd_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("drain_data", 32'(s_rd_data), 32'(i));
         check("drain_count", 32'(s_count), 32'(8 - i));
      end
      s_rd_en = 1'b0;
      check("drain_empty", 32'(s_empty), 32'd1);
      tick();
      check("drain_hold", 32'(s_rd_data), 32'd8);
      check("drain_no_unf", 32'(s_unf), 32'd0);

      // Empty with simultaneous read and write
      s_rd_en = 1'b1; s_wr_en = 1'b1; s_wr_data = 16'h00AA;
      tick();
      s_rd_en = 1'b0; s_wr_en = 1'b0;
      check("unf_pulse", 32'(s_unf), 32'd1);
      check("unf_count", 32'(s_count), 32'd1);
      check("unf_empty", 32'(s_empty), 32'd0);
      check("unf_rdata_hold", 32'(s_rd_data), 32'd8);
      tick();
      check("unf_clear", 32'(s_unf), 32'd0);
      s_rd_en = 1'b1;
      tick();
      s_rd_en = 1'b0;
      check("unf_read", 32'(s_rd_data), 32'h00AA);
      check("unf_read_count", 32'(s_count), 32'd0);

      // Full with simultaneous read and write
      s_wr_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         s_wr_data = 16'h0010 + 16'(i);
         tick();
      end
      check("f2_full", 32'(s_full), 32'd1);
      s_rd_en = 1'b1; s_wr_data = 16'hBEEF;
      tick();
      s_wr_en = 1'b0; s_rd_en = 1'b0;
      check("rw_full_data", 32'(s_rd_data), 32'h0011);
      check("rw_full_count", 32'(s_count), 32'd7);
      check("rw_full_ovf", 32'(s_ovf), 32'd1);
      check("rw_full_full", 32'(s_full), 32'd0);
      s_rd_en = 1'b1;
      for (int i = 2; i <= 8; i++) begin
         tick();
         check("rw_drain_data", 32'(s_rd_data), 32'h0010 + 32'(i));
      end
      s_rd_en = 1'b0;
      check("rw_drain_empty", 32'(s_empty), 32'd1);

      // FWFT: head word visible without rd_en
      check("fwft_idle_empty", 32'(f_empty), 32'd1);
      f_wr_en = 1'b1; f_wr_data = 16'h1234;
      tick();
      f_wr_en = 1'b0;
      check("fwft_empty", 32'(f_empty), 32'd0);
      check("fwft_data", 32'(f_rd_data), 32'h1234);
      check("fwft_count", 32'(f_count), 32'd1);
      tick();
      check("fwft_data_hold", 32'(f_rd_data), 32'h1234);
      q.push_back(16'h1234);

      // Random traffic against a queue model
      for (int c = 0; c < 20; c++) begin
         wr = ($urandom_range(3, 0) != 0);
         rd = ($urandom_range(1, 0) != 0);
         f_wr_en = wr;
         f_rd_en = rd;
         f_wr_data = 16'($urandom);
         if (q.size() > 0) begin
            check("rnd_head", 32'(f_rd_data), 32'(q[0]));
         end
         wacc = wr && (q.size() != 8);
         racc = rd && (q.size() != 0);
         exp_ovf = wr && (q.size() == 8);
         if (racc) void'(q.pop_front());
         if (wacc) q.push_back(f_wr_data);
         tick();
         check("rnd_count", 32'(f_count), 32'(q.size()));
         check("rnd_full", 32'(f_full), (q.size() == 8) ? 32'd1 : 32'd0);
         check("rnd_empty", 32'(f_empty), (q.size() == 0) ? 32'd1 : 32'd0);
         check("rnd_ovf", 32'(f_ovf), 32'(exp_ovf));
      end
      f_wr_en = 1'b0;
      f_rd_en = 1'b0;

      // Drain what remains and confirm order survives the pointer wrap
      for (int c = 0; c < 10; c++) begin
         if (q.size() > 0) begin
            check("tail_head", 32'(f_rd_data), 32'(q[0]));
            f_rd_en = 1'b1;
            void'(q.pop_front());
            tick();
            f_rd_en = 1'b0;
            check("tail_count", 32'(f_count), 32'(q.size()));
         end
      end
      check("tail_empty", 32'(f_empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
